axi_wr_slave_32: RTL and testbench



---
 rtl/axi_pkg.sv | 27 ++
 rtl/axi_burst_addr.sv | 44 ++++
 rtl/axi_wr_slave_32.sv | 134 +++++++++++++
 tb/tb_axi_wr_slave_32.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the write-channel responder.
// Contents: burst codes, response codes, legal beat size, FSM state encoding,
// and a helper that checks whether a WRAP burst length is legal.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    // Only 4-byte beats exist on a 32-bit data path.
    localparam logic [2:0] SIZE_4B     = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // A WRAP burst must be 2, 4, 8 or 16 beats long.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address generator for 4-byte beats.
// Macro: AXI_WR_SLAVE_WRAP_EN builds the WRAP path; otherwise WRAP is not
// built and the address is simply held (the burst is flagged illegal upstream).
// Ports:
//   addr      - current beat address
//   burst     - captured awburst
//   len       - captured awlen (beats minus 1)
//   next_addr - address of the following beat
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int ADDRWID = 32
) (
    input  logic [ADDRWID-1:0] addr,
    input  logic [1:0]         burst,
    input  logic [7:0]         len,
    output logic [ADDRWID-1:0] next_addr
);

    logic [ADDRWID-1:0] incr_addr;
    assign incr_addr = addr + ADDRWID'(4);

`ifdef AXI_WR_SLAVE_WRAP_EN
    // Legal wrap lengths are 2^n-1, so the window byte mask is just {len, 2'b11}.
    logic [ADDRWID-1:0] wrap_mask;
    assign wrap_mask = ADDRWID'({len, 2'b11});
`else
    logic unused_len;
    assign unused_len = ^len;
`endif

    always_comb begin
        next_addr = addr;
        case (burst)
            BURST_INCR: next_addr = incr_addr;
`ifdef AXI_WR_SLAVE_WRAP_EN
            // Keep the window base bits, let only the offset bits roll over.
            BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
`endif
            default:    next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_wr_slave_32.sv
// Single-outstanding AXI4 write responder, 32-bit data path.
// Accepts one AW burst, turns each W beat into a local write strobe at an
// incrementing/fixed/wrapping address, then returns one B response.
// Macro: AXI_WR_SLAVE_WRAP_EN enables WRAP bursts; without it WRAP is SLVERR.
// Ports:
//   clk, rst_n (sync, active-low), softreset (sync clear)
//   AW: awid, awaddr, awlen, awsize, awburst, awvalid, awready
//   W : wdata, wstrb, wlast, wvalid, wready
//   B : bid, bresp, bvalid, bready
//   local_wr/local_addr/local_wdata/local_wstrb - local write port
module axi_wr_slave_32
    import axi_pkg::*;
#(
    parameter int IDWID   = 4,
    parameter int ADDRWID = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               softreset,
    input  logic [IDWID-1:0]   awid,
    input  logic [ADDRWID-1:0] awaddr,
    input  logic [7:0]         awlen,
    input  logic [2:0]         awsize,
    input  logic [1:0]         awburst,
    input  logic               awvalid,
    output logic               awready,
    input  logic [31:0]        wdata,
    input  logic [3:0]         wstrb,
    input  logic               wlast,
    input  logic               wvalid,
    output logic               wready,
    output logic [IDWID-1:0]   bid,
    output logic [1:0]         bresp,
    output logic               bvalid,
    input  logic               bready,
    output logic               local_wr,
    output logic [ADDRWID-1:0] local_addr,
    output logic [31:0]        local_wdata,
    output logic [3:0]         local_wstrb
);

    state_t             state_q, state_d;
    logic [IDWID-1:0]   id_q;
    logic [ADDRWID-1:0] addr_q, addr_nxt;
    logic [7:0]         len_q, cnt_q;
    logic [1:0]         burst_q;
    logic               err_q;
    logic               clr, aw_hs, beat, last_beat, aw_err;

    assign clr       = !rst_n || softreset;
    assign aw_hs     = awvalid && awready;
    assign beat      = wvalid && wready;
    assign last_beat = (cnt_q == len_q);

    // Request legality, judged once at AW time.
    always_comb begin
        aw_err = (awsize != SIZE_4B);
        case (awburst)
            BURST_FIXED, BURST_INCR: ;
`ifdef AXI_WR_SLAVE_WRAP_EN
            BURST_WRAP: if (!wrap_len_ok(awlen) || (awaddr[1:0] != 2'b00)) aw_err = 1'b1;
`endif
            default:    aw_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Ready/valid decode from registered state only; awready is also held
    // low while a clear is pending so no request is lost to the reset.
    always_comb begin
        state_d = state_q;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                awready = !clr;
                if (aw_hs) state_d = ST_DATA;
            end
            ST_DATA: begin
                wready = 1'b1;
                if (beat && last_beat) state_d = ST_RESP;
            end
            ST_RESP: begin
                bvalid = 1'b1;
                if (bready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
        end else if (aw_hs) begin
            id_q    <= awid;
            addr_q  <= awaddr;
            len_q   <= awlen;
            cnt_q   <= '0;
            burst_q <= awburst;
            err_q   <= aw_err;
        end else if (beat) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= addr_nxt;
            // The beat count, not wlast, ends the burst; a misplaced or
            // missing wlast only poisons the response.
            if (last_beat ? !wlast : wlast) err_q <= 1'b1;
        end
    end

    axi_burst_addr #(.ADDRWID(ADDRWID)) u_burst_addr (
        .addr      (addr_q),
        .burst     (burst_q),
        .len       (len_q),
        .next_addr (addr_nxt)
    );

    assign local_wr    = beat && !err_q;
    assign local_addr  = addr_q;
    assign local_wdata = wdata;
    assign local_wstrb = wstrb;
    assign bid         = id_q;
    assign bresp       = (state_q == ST_RESP && err_q) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_wr_slave_32.sv
module tb_axi_wr_slave_32;

    logic        clk, rst_n, softreset;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic        local_wr;
    logic [31:0] local_addr, local_wdata;
    logic [3:0]  local_wstrb;

    int total = 0;
    int bad   = 0;

    logic [31:0] wr_q[$];
    logic [31:0] wd_q[$];
    int          hs_n;
    logic [1:0]  r_resp;
    logic [3:0]  r_id;
    bit          tmo;

    axi_wr_slave_32 #(.IDWID(4), .ADDRWID(32)) dut (
        .clk(clk), .rst_n(rst_n), .softreset(softreset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .local_wr(local_wr), .local_addr(local_addr),
        .local_wdata(local_wdata), .local_wstrb(local_wstrb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drives one full transaction and records what came out; tests judge it.
    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int wl_beat);
        int n;
        wr_q.delete(); wd_q.delete();
        hs_n = 0; tmo = 0; r_resp = 2'bxx; r_id = 4'bxxxx;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        #1 n = 0;
        while (!awready && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) tmo = 1;
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = 32'hA500_0000 + i; wstrb = 4'hF; wlast = (i == wl_beat); wvalid = 1'b1;
            #1 n = 0;
            while (!wready && n < 20) begin @(negedge clk); #1; n++; end
            if (n >= 20) tmo = 1;
            hs_n++;
            if (local_wr) begin wr_q.push_back(local_addr); wd_q.push_back(local_wdata); end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        #1 n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) tmo = 1;
        r_resp = bresp; r_id = bid;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; softreset = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'd1;
        wdata = '0; wstrb = '0; wlast = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({awready, wready, bvalid, bid, bresp, local_wr, local_addr} !== {1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL reset_outputs got aw=%b w=%b b=%b bid=%h bresp=%0d lwr=%b laddr=%h",
                     awready, wready, bvalid, bid, bresp, local_wr, local_addr);
        end
        rst_n = 1'b1;
        @(negedge clk); #1;
        total++;
        if ({awready, wready, bvalid} !== 3'b100) begin
            bad++; $display("FAIL reset_release got aw=%b w=%b b=%b exp aw=1 w=0 b=0", awready, wready, bvalid);
        end
    endtask

    task automatic test_single_beat_timing();
        @(negedge clk);
        awid = 4'h3; awaddr = 32'h500; awlen = 8'd0; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
        wvalid = 1'b1; wlast = 1'b1; wdata = 32'h1234_5678; wstrb = 4'h6;
        #1;
        total++;
        if ({awready, wready, local_wr} !== 3'b100) begin
            bad++; $display("FAIL early_w got aw=%b w=%b lwr=%b exp 1 0 0", awready, wready, local_wr);
        end
        @(negedge clk); awvalid = 1'b0; #1;
        total++;
        if ({wready, local_wr, local_addr, local_wdata, local_wstrb} !== {1'b1, 1'b1, 32'h500, 32'h1234_5678, 4'h6}) begin
            bad++; $display("FAIL beat_n1 got w=%b lwr=%b addr=%h data=%h strb=%h", wready, local_wr, local_addr, local_wdata, local_wstrb);
        end
        @(negedge clk); wvalid = 1'b0; wlast = 1'b0; #1;
        total++;
        if ({bvalid, wready, bresp, bid} !== {1'b1, 1'b0, 2'd0, 4'h3}) begin
            bad++; $display("FAIL resp_n2 got b=%b w=%b bresp=%0d bid=%h exp b=1 w=0 0 3", bvalid, wready, bresp, bid);
        end
        bready = 1'b1;
        @(negedge clk); bready = 1'b0; #1;
        total++;
        if ({awready, bvalid} !== 2'b10) begin
            bad++; $display("FAIL turnaround got aw=%b b=%b exp aw=1 b=0", awready, bvalid);
        end
    endtask

    task automatic test_incr();
        run_burst(4'h5, 32'h100, 8'd3, 3'd2, 2'd1, 3);
        total++;
        if ({tmo, 3'(hs_n), r_resp, r_id} !== {1'b0, 3'd4, 2'd0, 4'h5}) begin
            bad++; $display("FAIL incr_resp got tmo=%0d hs=%0d resp=%0d id=%h exp 0 4 0 5", tmo, hs_n, r_resp, r_id);
        end
        total++;
        if (wr_q.size() != 4) begin
            bad++; $display("FAIL incr_count got %0d exp 4", wr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (wr_q[i] !== 32'h100 + 32'(4 * i) || wd_q[i] !== 32'hA500_0000 + 32'(i)) begin
                    bad++; $display("FAIL incr_beat%0d got addr=%h data=%h exp addr=%h", i, wr_q[i], wd_q[i], 32'h100 + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [4];
        exp_a[0] = 32'h208; exp_a[1] = 32'h20C; exp_a[2] = 32'h200; exp_a[3] = 32'h204;
        run_burst(4'hA, 32'h208, 8'd3, 3'd2, 2'd2, 3);
`ifdef AXI_WR_SLAVE_WRAP_EN
        total++;
        if ({tmo, r_resp, r_id} !== {1'b0, 2'd0, 4'hA}) begin
            bad++; $display("FAIL wrap_resp got tmo=%0d resp=%0d id=%h exp 0 0 a", tmo, r_resp, r_id);
        end
        total++;
        if (wr_q.size() != 4) begin
            bad++; $display("FAIL wrap_count got %0d exp 4", wr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (wr_q[i] !== exp_a[i]) begin
                    bad++; $display("FAIL wrap_beat%0d got %h exp %h", i, wr_q[i], exp_a[i]);
                end
            end
        end
        // 3-beat WRAP is not a legal length
        run_burst(4'hB, 32'h300, 8'd2, 3'd2, 2'd2, 2);
        total++;
        if ({tmo, 3'(hs_n), 3'(wr_q.size()), r_resp} !== {1'b0, 3'd3, 3'd0, 2'd2}) begin
            bad++; $display("FAIL wrap_badlen got tmo=%0d hs=%0d wr=%0d resp=%0d exp 0 3 0 2", tmo, hs_n, wr_q.size(), r_resp);
        end
`else
        total++;
        if ({tmo, 3'(hs_n), 3'(wr_q.size()), r_resp, r_id} !== {1'b0, 3'd4, 3'd0, 2'd2, 4'hA}) begin
            bad++; $display("FAIL wrap_disabled got tmo=%0d hs=%0d wr=%0d resp=%0d id=%h exp 0 4 0 2 a (first addr %h)",
                            tmo, hs_n, wr_q.size(), r_resp, r_id, exp_a[0]);
        end
`endif
    endtask

    task automatic test_fixed();
        run_burst(4'h1, 32'h40, 8'd2, 3'd2, 2'd0, -1);
        total++;
        if ({tmo, 3'(hs_n), r_resp} !== {1'b0, 3'd3, 2'd2}) begin
            bad++; $display("FAIL fixed_nolast got tmo=%0d hs=%0d resp=%0d exp 0 3 2", tmo, hs_n, r_resp);
        end
        total++;
        if (wr_q.size() != 3) begin
            bad++; $display("FAIL fixed_count got %0d exp 3", wr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (wr_q[i] !== 32'h40) begin
                    bad++; $display("FAIL fixed_beat%0d got %h exp 00000040", i, wr_q[i]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        run_burst(4'h2, 32'h80, 8'd1, 3'd3, 2'd1, 1);
        total++;
        if ({tmo, 3'(hs_n), 3'(wr_q.size()), r_resp} !== {1'b0, 3'd2, 3'd0, 2'd2}) begin
            bad++; $display("FAIL awsize3 got tmo=%0d hs=%0d wr=%0d resp=%0d exp 0 2 0 2", tmo, hs_n, wr_q.size(), r_resp);
        end
        run_burst(4'h4, 32'h80, 8'd1, 3'd2, 2'd3, 1);
        total++;
        if ({tmo, 3'(hs_n), 3'(wr_q.size()), r_resp} !== {1'b0, 3'd2, 3'd0, 2'd2}) begin
            bad++; $display("FAIL burst3 got tmo=%0d hs=%0d wr=%0d resp=%0d exp 0 2 0 2", tmo, hs_n, wr_q.size(), r_resp);
        end
        // wlast on beat 0 of 3: burst still runs 3 beats, later beats suppressed
        run_burst(4'h6, 32'h80, 8'd2, 3'd2, 2'd1, 0);
        total++;
        if ({tmo, 3'(hs_n), 3'(wr_q.size()), r_resp} !== {1'b0, 3'd3, 3'd1, 2'd2}) begin
            bad++; $display("FAIL early_wlast got tmo=%0d hs=%0d wr=%0d resp=%0d exp 0 3 1 2", tmo, hs_n, wr_q.size(), r_resp);
        end
    endtask

    task automatic test_bready_hold();
        @(negedge clk);
        awid = 4'h9; awaddr = 32'h600; awlen = 8'd0; awsize = 3'd3; awburst = 2'd1; awvalid = 1'b1;
        wvalid = 1'b1; wlast = 1'b1;
        @(negedge clk); awvalid = 1'b0;
        @(negedge clk); wvalid = 1'b0; wlast = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if ({bvalid, bid, bresp, awready} !== {1'b1, 4'h9, 2'd2, 1'b0}) begin
                bad++; $display("FAIL bhold_c%0d got b=%b bid=%h bresp=%0d aw=%b exp 1 9 2 0", c, bvalid, bid, bresp, awready);
            end
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk); bready = 1'b0; #1;
        total++;
        if ({awready, bvalid} !== 2'b10) begin
            bad++; $display("FAIL bhold_release got aw=%b b=%b exp 1 0", awready, bvalid);
        end
    endtask

    task automatic test_softreset();
        @(negedge clk);
        awid = 4'h7; awaddr = 32'h300; awlen = 8'd3; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
        @(negedge clk); awvalid = 1'b0; wvalid = 1'b1; wlast = 1'b0;
        @(negedge clk); softreset = 1'b1; #1;
        total++;
        if (local_addr !== 32'h304) begin
            bad++; $display("FAIL sr_beat2_addr got %h exp 00000304", local_addr);
        end
        @(negedge clk); softreset = 1'b0; wvalid = 1'b0; #1;
        total++;
        if ({wready, awready, local_addr} !== {1'b0, 1'b1, 32'h0}) begin
            bad++; $display("FAIL sr_idle got w=%b aw=%b addr=%h exp 0 1 0", wready, awready, local_addr);
        end
        bready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            total++;
            if (bvalid !== 1'b0) begin
                bad++; $display("FAIL sr_nob_c%0d got bvalid=%b exp 0", c, bvalid);
            end
        end
        bready = 1'b0;
        // recovery burst after the clear
        run_burst(4'hC, 32'h10, 8'd1, 3'd2, 2'd1, 1);
        total++;
        if ({tmo, 3'(wr_q.size()), r_resp, r_id} !== {1'b0, 3'd2, 2'd0, 4'hC}) begin
            bad++; $display("FAIL sr_recover got tmo=%0d wr=%0d resp=%0d id=%h exp 0 2 0 c", tmo, wr_q.size(), r_resp, r_id);
        end else begin
            total++;
            if (wr_q[0] !== 32'h10 || wr_q[1] !== 32'h14) begin
                bad++; $display("FAIL sr_recover_addr got %h %h exp 00000010 00000014", wr_q[0], wr_q[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat_timing();
        test_incr();
        test_wrap();
        test_fixed();
        test_illegal();
        test_bready_hold();
        test_softreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
